// File: rtl/counter_fsm_mod.sv
// rtl/counter_fsm_mod.sv - FSM-controlled up/down counter with load, wrap/one-shot modes and status flags
//
// Purpose:
//   Event/timeout counter used by other control FSMs. Counts up or down between
//   0 and MAX_COUNT, with a synchronous load, a wrap (continuous) or one-shot
//   mode, a one-cycle terminal-count pulse and a sticky one-shot done flag.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset, clears all state immediately
//   i_en        count enable
//   i_up_dn     direction: 1 = up, 0 = down
//   i_load      synchronous load strobe (highest priority)
//   i_load_val  load value, saturated to MAX_COUNT
//   i_mode      0 = wrap, 1 = one-shot
//   o_count     current count
//   o_tc        terminal-count pulse (one cycle per step that reaches the terminal value)
//   o_done      one-shot finished, sticky until load or reset
//   o_busy      high while the FSM is in RUN

module counter_fsm_mod #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_done,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;

  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_step_en;

  // Terminal value, next stepped value and saturated load value all follow
  // the inputs sampled at this edge, so direction changes never add a step.
  always_comb begin
    w_term     = i_up_dn ? L_MAX : '0;
    w_load_sat = (i_load_val > L_MAX) ? L_MAX : i_load_val;
    if (i_up_dn) begin
      w_step = (r_count == L_MAX) ? '0 : r_count + 1'b1;
    end else begin
      w_step = (r_count == '0) ? L_MAX : r_count - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_step_en   = 1'b0;

    if (i_load) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = w_load_sat;
      w_done_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_PAUSE: begin
          if (i_en) begin
            w_step_en = 1'b1;
          end
        end
        S_RUN: begin
          if (i_en) begin
            w_step_en = 1'b1;
          end else begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_DONE: begin
          // Held until load or reset; en and up_dn have no effect here.
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      if (w_step_en) begin
        w_count_nxt = w_step;
        w_state_nxt = S_RUN;
        if (w_step == w_term) begin
          w_tc_nxt = 1'b1;
          if (i_mode) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
      // busy is registered alongside state so it always equals (state == RUN).
      r_busy  <= (w_state_nxt == S_RUN);
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_done  = r_done;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_counter_fsm_mod.sv
// tb/tb_counter_fsm_mod.sv - directed self-checking bench for counter_fsm_mod (WIDTH=4, MAX_COUNT=9)

module tb_counter_fsm_mod;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       mode;
  logic [3:0] count;
  logic       tc;
  logic       done;
  logic       busy;

  int n_cmp;
  int n_fail;

  counter_fsm_mod #(
    .WIDTH     (4),
    .MAX_COUNT (9)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_up_dn    (up_dn),
    .i_load     (load),
    .i_load_val (load_val),
    .i_mode     (mode),
    .o_count    (count),
    .o_tc       (tc),
    .o_done     (done),
    .o_busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle 1 ns after the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0; mode = 1'b0;
    #6;
    n_cmp++;
    if ({count, tc, done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got count=%0d tc=%b done=%b busy=%b, want 0 0 0 0", count, tc, done, busy);
    end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      n_cmp++;
      if ({count, tc, done, busy} !== 7'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got count=%0d tc=%b done=%b busy=%b, want 0 0 0 0", i, count, tc, done, busy);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_cnt [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    mode = 1'b0; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if (count !== exp_cnt[i] || tc !== (i == 8) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL up_wrap_step%0d: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=1 done=0",
                 i, count, tc, busy, done, exp_cnt[i], (i == 8));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_sat();
    logic [3:0] exp_cnt [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    step();
    n_cmp++;
    if (count !== 4'd9 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_saturate: got count=%0d busy=%b tc=%b, want count=9 busy=0 tc=0", count, busy, tc);
    end
    load_val = 4'd2;
    step();
    n_cmp++;
    if (count !== 4'd2) begin
      n_fail++;
      $display("FAIL load_2: got count=%0d, want 2", count);
    end
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (count !== exp_cnt[i] || tc !== (i == 1) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL down_wrap_step%0d: got count=%0d tc=%b busy=%b, want count=%0d tc=%b busy=1",
                 i, count, tc, busy, exp_cnt[i], (i == 1));
      end
    end
    en = 1'b0; up_dn = 1'b1;
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_cnt;
    en = 1'b0; mode = 1'b1; load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; up_dn = 1'b1; en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      exp_cnt = (i < 9) ? 4'(i) : 4'd9;
      n_cmp++;
      if (count !== exp_cnt || tc !== (i == 9) || done !== (i >= 9) || busy !== (i < 9)) begin
        n_fail++;
        $display("FAIL one_shot_step%0d: got count=%0d tc=%b done=%b busy=%b, want count=%0d tc=%b done=%b busy=%b",
                 i, count, tc, done, busy, exp_cnt, (i == 9), (i >= 9), (i < 9));
      end
    end
    // Direction flip while in DONE must not move the count.
    up_dn = 1'b0;
    step();
    n_cmp++;
    if (count !== 4'd9 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignores_dir: got count=%0d done=%b, want count=9 done=1", count, done);
    end
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 4'd0;
    step();
    n_cmp++;
    if (count !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL one_shot_reload: got count=%0d done=%b busy=%b, want 0 0 0", count, done, busy);
    end
    load = 1'b0; en = 1'b1;
    step();
    n_cmp++;
    if (count !== 4'd1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL one_shot_restart: got count=%0d busy=%b done=%b, want 1 1 0", count, busy, done);
    end
    en = 1'b0;
  endtask

  task automatic test_load_vs_terminal();
    mode = 1'b1; up_dn = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd8;
    step();
    // en would reach T=9 this edge, but load wins.
    en = 1'b1; load_val = 4'd3;
    step();
    n_cmp++;
    if (count !== 4'd3 || tc !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_beats_tc: got count=%0d tc=%b done=%b busy=%b, want count=3 tc=0 done=0 busy=0",
               count, tc, done, busy);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_pause_reset();
    mode = 1'b0; up_dn = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_prefill: got count=%0d busy=%b, want 5 1", count, busy);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (count !== 4'd5 || busy !== 1'b0 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got count=%0d busy=%b tc=%b, want 5 0 0", i, count, busy, tc);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (count !== 4'(6 + i) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL resume_step%0d: got count=%0d busy=%b, want %0d 1", i, count, busy, 6 + i);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, tc, done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: got count=%0d tc=%b done=%b busy=%b, want 0 0 0 0", count, tc, done, busy);
    end
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got count=%0d busy=%b, want 0 0", count, busy);
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (count !== 4'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_count: got count=%0d busy=%b, want 1 1", count, busy);
    end
    en = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_one_shot();
    test_load_vs_terminal();
    test_pause_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
